float_div_seq: RTL and testbench
================================

// Module: float_div_seq
// PURPOSE
//  Iterative (one quotient bit per cycle) divider for the coprocessor's reduced float format.
//  Computes result = a / b. It is the inverse operation of the package's combinational multiplier.
//  Sits beside the add/sub/mul datapath and is driven by the coprocessor control FSM.
//  Operand format: {s, e[NE-1:0], m[NM-1:0]}, bias DE = 2**(NE-1)-1.
//  Hidden bit is 1 when e != 0; e == 0 means zero. No inf/NaN; truncation only, no rounding.
// PARAMETERS
//  NM  23  mantissa width, legal range 1..23
//  NE  8   exponent width, legal range 2..8
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          asynchronous, active-high
//  start         in   1          request; sampled only while ready=1
//  a             in   1+NE+NM    dividend
//  b             in   1+NE+NM    divisor
//  ready         out  1          1 in IDLE only
//  done          out  1          1-cycle pulse; result/div_by_zero valid from this cycle
//  result        out  1+NE+NM    quotient; held until the next done
//  div_by_zero   out  1          set with done when b.e == 0; held like result
// BEHAVIOUR
//  Reset values: ready=1, done=0, result=0, div_by_zero=0, state=IDLE.
//  Reset mid-operation aborts the operation; no done is produced.
//  Registers are written on the rising edge only.
//  FSM: IDLE -> DIV -> NORM -> IDLE.
//  - IDLE & start: latch sign a.s^b.s, exponent difference, and flags az=(a.e==0), bz=(b.e==0).
//    Load rem={1'b0,1,a.m}, dvs={1,b.m}, cnt=NM+1, q=0. Go to DIV.
//  - DIV, one step per edge: if rem>=dvs then q={q,1}, rem=(rem-dvs)<<1; else q={q,0}, rem=rem<<1.
//    Go to NORM after the step with cnt==0; otherwise cnt-=1. This gives NM+2 steps.
//    The steps run even for special operands, so latency is fixed.
//  - NORM: register result, pulse done, return to IDLE.
//  Latency: start accepted on edge k; done=1 in the cycle after edge k+NM+3 (26 cycles for 23/8).
//  start while ready=0 is ignored; there is no queueing.
//  Back-to-back: ready is 1 again in the done cycle; a start there is accepted.
//  q width NM+2, q = floor(ma/mb * 2**(NM+1)).
//  Normalisation:
//    if q[NM+1]: m=q[NM:1], E = a.e - b.e + DE
//    else:       m=q[NM-1:0], E = a.e - b.e + DE - 1
//    E is computed signed, width NE+2.
//  Priority of outcomes:
//    1. bz: e=2**NE-2, m=all ones, s=a.s^b.s, div_by_zero=1 (also when az=1).
//    2. az: e=0, m=0, s=a.s^b.s.
//    3. E >= 2**NE-1: saturate to e=2**NE-2, m=all ones.
//    4. E <= 0: flush to e=0, m=0, sign kept.
//    5. Otherwise e=E[NE-1:0].
//  div_by_zero=0 in every case except bz.
// TESTING (NM=23, NE=8; all values shown as IEEE hex)
//  40C00000 / 40000000 (6/2) -> 40400000, div_by_zero=0, done exactly 26 cycles after start.
//  3F800000 / 40400000 (1/3) -> 3EAAAAAA (truncated); C0C00000 / 40000000 -> C0400000.
//  3F800000 / 00000000 -> 7F7FFFFF, div_by_zero=1.
//  00000000 / 00000000 -> 7F7FFFFF, div_by_zero=1.
//  00000000 / 40000000 -> 00000000, div_by_zero=0.
//  7F000000 / 3E800000 -> 7F7FFFFF (overflow saturates, div_by_zero=0).
//  00800000 / 40000000 -> 00000000 (underflow flush).
//  start held high for 60 cycles -> exactly two done pulses; operands changed mid-op are ignored.
//  reset pulsed at cycle 10 of an operation -> no done pulse, ready=1.
//  Next start then completes normally.
//  Random: 10k normal pairs vs the package's $bitstoshortreal model.
//  Mantissa must match the truncated reference exactly, and exponent/sign must match.

Source files
------------

// File: rtl/float_div_seq.sv
// Sequential restoring divider for the reduced float format: one quotient bit per cycle,
// truncating result, saturation on overflow, flush-to-zero on underflow.
module float_div_seq #(
  parameter int NM = 23,
  parameter int NE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NE+NM:0]   a,
  input  logic [NE+NM:0]   b,
  output logic             ready,
  output logic             done,
  output logic [NE+NM:0]   result,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // DIV   | one quotient bit per edge, NM+2 steps
  // NORM  | normalise, register result, pulse done
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  localparam int CW = $clog2(NM + 2);
  localparam logic [CW-1:0]        CNT_INIT = CW'(NM + 1);
  localparam logic signed [NE+1:0] E_BIAS   = (NE+2)'(2**(NE-1) - 1);
  localparam logic signed [NE+1:0] E_OVF    = (NE+2)'(2**NE - 1);
  localparam logic [NE-1:0]        E_SAT    = NE'(2**NE - 2);

  state_t state, state_nxt;

  logic                  sgn, az, bz;
  logic [NE+1:0]         ediff;
  logic [NM+1:0]         rem;
  logic [NM:0]           dvs;
  logic [NM+1:0]         q;
  logic [CW-1:0]         cnt;

  logic                  rem_ge;
  logic [NM:0]           rem_sub;
  logic [NM+1:0]         rem_nxt;
  logic signed [NE+1:0]  e_full;
  logic [NM-1:0]         m_norm;
  logic [NE+NM:0]        res_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = DIV;
      end
      DIV:     if (cnt == '0) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rem stays below 2*dvs, so the difference always fits in NM+1 bits
  always_comb begin
    rem_ge  = (rem >= {1'b0, dvs});
    rem_sub = rem[NM:0] - dvs;
    rem_nxt = rem_ge ? {rem_sub, 1'b0} : {rem[NM:0], 1'b0};
  end

  always_comb begin
    e_full = ediff + E_BIAS - {{(NE+1){1'b0}}, ~q[NM+1]};
    m_norm = q[NM+1] ? q[NM:1] : q[NM-1:0];
    if (bz)
      res_nxt = {sgn, E_SAT, {NM{1'b1}}};
    else if (az)
      res_nxt = {sgn, {NE{1'b0}}, {NM{1'b0}}};
    else if (e_full >= E_OVF)
      res_nxt = {sgn, E_SAT, {NM{1'b1}}};
    else if (e_full[NE+1] || e_full == '0)
      res_nxt = {sgn, {NE{1'b0}}, {NM{1'b0}}};
    else
      res_nxt = {sgn, e_full[NE-1:0], m_norm};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn         <= 1'b0;
      az          <= 1'b0;
      bz          <= 1'b0;
      ediff       <= '0;
      rem         <= '0;
      dvs         <= '0;
      q           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sgn   <= a[NE+NM] ^ b[NE+NM];
          az    <= (a[NE+NM-1:NM] == '0);
          bz    <= (b[NE+NM-1:NM] == '0);
          ediff <= {2'b00, a[NE+NM-1:NM]} - {2'b00, b[NE+NM-1:NM]};
          rem   <= {2'b01, a[NM-1:0]};
          dvs   <= {1'b1, b[NM-1:0]};
          q     <= '0;
          cnt   <= CNT_INIT;
        end
        DIV: begin
          q   <= {q[NM:0], rem_ge};
          rem <= rem_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        NORM: begin
          result      <= res_nxt;
          div_by_zero <= bz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_seq.sv
// Directed bench for float_div_seq (NM=23, NE=8): reset, result table, fixed latency,
// done pulse shape, held start with operand changes, and reset abort.
module tb_float_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        ready, done, div_by_zero;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  float_div_seq #(.NM(23), .NE(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] r, output logic dz,
                        output int lat, output bit to);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    to = (lat >= 100);
    r  = result;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    vec_t v[16];
    logic [31:0] r;
    logic dz;
    int lat;
    bit to;
    v[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
    v[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
    v[2]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};
    v[3]  = '{32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 1'b1};
    v[4]  = '{32'h00000000, 32'h00000000, 32'h7F7FFFFF, 1'b1};
    v[5]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
    v[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 1'b0};
    v[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0};
    v[8]  = '{32'h3F800000, 32'hC0000000, 32'hBF000000, 1'b0};
    v[9]  = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0};
    v[10] = '{32'hBF800000, 32'h00000000, 32'hFF7FFFFF, 1'b1};
    v[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0};
    v[12] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0};
    v[13] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0};
    v[14] = '{32'h80800000, 32'h40000000, 32'h80000000, 1'b0};
    v[15] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].a, v[i].b, r, dz, lat, to);
      total++;
      if (to) begin
        bad++; $display("FAIL vec%0d_timeout no done within %0d cycles", i, lat);
      end else begin
        if (r !== v[i].r) begin bad++; $display("FAIL vec%0d_result %h/%h got=%h want=%h", i, v[i].a, v[i].b, r, v[i].r); end
        total++;
        if (dz !== v[i].dz) begin bad++; $display("FAIL vec%0d_dbz got=%b want=%b", i, dz, v[i].dz); end
        total++;
        if (lat !== 26) begin bad++; $display("FAIL vec%0d_latency got=%0d want=26", i, lat); end
      end
    end
  endtask

  task automatic test_pulse();
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", ready); end
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL pulse_seen got=%b want=1", done); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_in_done got=%b want=1", ready); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b want=0", done); end
    repeat (3) @(negedge clk);
    total++; if (result !== 32'h40400000) begin bad++; $display("FAIL result_hold got=%h want=40400000", result); end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    logic [31:0] res[2];
    res[0] = '0; res[1] = '0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 4) begin a = 32'h3F800000; b = 32'h40400000; end
      if (done === 1'b1) begin
        if (n_done < 2) res[n_done] = result;
        n_done++;
      end
    end
    start = 1'b0;
    total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", n_done); end
    total++; if (res[0] !== 32'h40400000) begin bad++; $display("FAIL b2b_first got=%h want=40400000", res[0]); end
    total++; if (res[1] !== 32'h3EAAAAAA) begin bad++; $display("FAIL b2b_second got=%h want=3EAAAAAA", res[1]); end
    for (int i = 0; i < 60 && !(ready === 1'b1 && done === 1'b0); i++) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%b want=1", ready); end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    logic [31:0] r;
    logic dz;
    int lat;
    bit to;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h want=00000000", result); end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", n_done); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b want=1", ready); end
    run_op(32'h3F800000, 32'h40400000, r, dz, lat, to);
    total++; if (r !== 32'h3EAAAAAA || to) begin bad++; $display("FAIL after_abort_result got=%h want=3EAAAAAA", r); end
    total++; if (lat !== 26) begin bad++; $display("FAIL after_abort_latency got=%0d want=26", lat); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_pulse();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
